// File: rtl/ipdom_reconv_ctrl.sv
// ipdom_reconv_ctrl: per-warp IPDOM reconvergence stack sequencer.
// One split/join is accepted at a time. A divergent split pushes the
// reconvergence entry and then the not-taken entry. A join pops the top
// entry. Each operation ends with a one-cycle PC/mask update pulse.
module ipdom_reconv_ctrl #(
  parameter int NUM_WARPS   = 8,
  parameter int NUM_THREADS = 32,
  parameter int PC_WIDTH    = 32,
  parameter int STACK_DEPTH = 8,
  localparam int WID = $clog2(NUM_WARPS),
  localparam int SPW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic                   op_is_join,
  input  logic [WID-1:0]         op_warp_id,
  input  logic [NUM_THREADS-1:0] op_cur_mask,
  input  logic [NUM_THREADS-1:0] op_taken_mask,
  input  logic [PC_WIDTH-1:0]    op_taken_pc,
  input  logic [PC_WIDTH-1:0]    op_fallthru_pc,
  input  logic [PC_WIDTH-1:0]    op_ipdom_pc,
  input  logic                   flush_valid,
  input  logic [WID-1:0]         flush_warp_id,
  output logic                   upd_valid,
  output logic [WID-1:0]         upd_warp_id,
  output logic [PC_WIDTH-1:0]    upd_pc,
  output logic [NUM_THREADS-1:0] upd_mask,
  output logic                   upd_err,
  output logic [NUM_WARPS-1:0]   stack_empty,
  output logic [NUM_WARPS-1:0]   stack_full
);

  localparam int EW   = PC_WIDTH + NUM_THREADS;   // stack entry {pc, mask}
  localparam int NENT = NUM_WARPS * STACK_DEPTH;  // all warps share one array
  localparam int MAW  = $clog2(NENT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH_R = 3'd1,
    S_PUSH_N = 3'd2,
    S_POP    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operation fields latched at acceptance
  logic [WID-1:0]         r_warp;
  logic                   r_is_join;
  logic [PC_WIDTH-1:0]    r_ipdom_pc;
  logic [PC_WIDTH-1:0]    r_fall_pc;
  logic [NUM_THREADS-1:0] r_cur_mask;
  logic [NUM_THREADS-1:0] r_n_mask;
  // Response prepared at acceptance (joins take pc/mask from the stack read)
  logic [PC_WIDTH-1:0]    r_resp_pc;
  logic [NUM_THREADS-1:0] r_resp_mask;
  logic                   r_resp_err;

  // Entry storage and its registered read port
  logic [EW-1:0] r_mem [NENT];
  logic [EW-1:0] r_rd_data;

  logic                   w_accept;
  logic [NUM_THREADS-1:0] w_t_mask;
  logic [NUM_THREADS-1:0] w_n_mask;
  logic                   w_t_zero;
  logic                   w_n_zero;
  logic                   w_acc_flush;
  logic [SPW-1:0]         w_sp [NUM_WARPS];
  logic [SPW-1:0]         w_sp_acc;
  logic [SPW-1:0]         w_sp_cur;
  logic                   w_room;
  logic                   w_join_under;
  logic                   w_split_div;
  logic                   w_flush_cur;
  logic                   w_abort;
  logic                   w_push;
  logic                   w_mem_we;
  logic                   w_mem_re;
  logic [MAW-1:0]         w_base;
  logic [MAW-1:0]         w_wr_addr;
  logic [MAW-1:0]         w_rd_addr;
  logic [EW-1:0]          w_wr_data;

  // ------------------------------------------------------------------
  // Acceptance-time decode (inputs are the values being latched)
  // ------------------------------------------------------------------
  assign w_accept = op_valid && op_ready;
  assign w_t_mask = op_taken_mask & op_cur_mask;
  assign w_n_mask = op_cur_mask & ~w_t_mask;
  assign w_t_zero = (w_t_mask == '0);
  assign w_n_zero = (w_n_mask == '0);

  // A flush hitting the warp in the accept cycle wins, so the op sees an empty stack.
  assign w_acc_flush  = flush_valid && (flush_warp_id == op_warp_id);
  assign w_sp_acc     = w_acc_flush ? '0 : w_sp[op_warp_id];
  assign w_room       = (w_sp_acc <= SPW'(STACK_DEPTH - 2));
  assign w_join_under = (w_sp_acc == '0);
  assign w_split_div  = !w_t_zero && !w_n_zero;

  // In-flight op status
  assign w_sp_cur    = w_sp[r_warp];
  assign w_flush_cur = flush_valid && (flush_warp_id == r_warp);
  assign w_push      = (r_state == S_PUSH_R) || (r_state == S_PUSH_N);
  assign w_abort     = w_flush_cur &&
                       ((r_state == S_PUSH_R) || (r_state == S_PUSH_N) || (r_state == S_POP));

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: route accepted ops, abort on a flush of the in-flight warp
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (op_is_join) begin
            w_state_next = w_join_under ? S_RESP : S_POP;
          end else if (w_split_div && w_room) begin
            w_state_next = S_PUSH_R;
          end else begin
            w_state_next = S_RESP;
          end
        end
      end
      S_PUSH_R: w_state_next = w_abort ? S_IDLE : S_PUSH_N;
      S_PUSH_N: w_state_next = w_abort ? S_IDLE : S_RESP;
      S_POP:    w_state_next = w_abort ? S_IDLE : S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Outputs: ready only when idle and out of reset, update pulse in RESP
  always_comb begin
    op_ready    = rst_n && (r_state == S_IDLE);
    upd_valid   = (r_state == S_RESP);
    upd_err     = (r_state == S_RESP) && r_resp_err;
    upd_warp_id = r_warp;
    if (r_is_join && !r_resp_err) begin
      upd_pc   = r_rd_data[EW-1:NUM_THREADS];
      upd_mask = r_rd_data[NUM_THREADS-1:0];
    end else begin
      upd_pc   = r_resp_pc;
      upd_mask = r_resp_mask;
    end
  end

  // ------------------------------------------------------------------
  // Operation latch and response preparation
  // ------------------------------------------------------------------

  // Capture operation fields and precompute the split/error response on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warp      <= '0;
      r_is_join   <= 1'b0;
      r_ipdom_pc  <= '0;
      r_fall_pc   <= '0;
      r_cur_mask  <= '0;
      r_n_mask    <= '0;
      r_resp_pc   <= '0;
      r_resp_mask <= '0;
      r_resp_err  <= 1'b0;
    end else if (w_accept) begin
      r_warp      <= op_warp_id;
      r_is_join   <= op_is_join;
      r_ipdom_pc  <= op_ipdom_pc;
      r_fall_pc   <= op_fallthru_pc;
      r_cur_mask  <= op_cur_mask;
      r_n_mask    <= w_n_mask;
      r_resp_pc   <= w_t_zero ? op_fallthru_pc : op_taken_pc;
      r_resp_mask <= (w_t_zero || w_n_zero) ? op_cur_mask : w_t_mask;
      r_resp_err  <= op_is_join ? w_join_under : (w_split_div && !w_room);
    end
  end

  // ------------------------------------------------------------------
  // Per-warp stack pointers and status
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      logic [SPW-1:0] r_sp;
      logic           w_hit;
      logic           w_fl;
      logic           w_inc;
      logic           w_dec;

      assign w_hit = (r_warp == WID'(gi));
      assign w_fl  = flush_valid && (flush_warp_id == WID'(gi));
      assign w_inc = w_hit && w_push;
      assign w_dec = w_hit && (r_state == S_POP);

      // Stack pointer: flush beats push/pop to the same warp
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sp <= '0;
        end else if (w_fl) begin
          r_sp <= '0;
        end else if (w_inc) begin
          r_sp <= r_sp + 1'b1;
        end else if (w_dec) begin
          r_sp <= r_sp - 1'b1;
        end
      end

      assign w_sp[gi]        = r_sp;
      assign stack_empty[gi] = (r_sp == '0);
      assign stack_full[gi]  = (r_sp > SPW'(STACK_DEPTH - 2));
    end
  endgenerate

  // ------------------------------------------------------------------
  // Entry storage: PUSH_R writes at sp, PUSH_N at sp+1 (sp already bumped),
  // POP reads sp-1. Warp w owns entries [w*STACK_DEPTH, (w+1)*STACK_DEPTH).
  // ------------------------------------------------------------------
  assign w_base    = MAW'(r_warp) * MAW'(STACK_DEPTH);
  assign w_wr_addr = w_base + MAW'(w_sp_cur);
  assign w_rd_addr = w_wr_addr - 1'b1;
  assign w_wr_data = (r_state == S_PUSH_R) ? {r_ipdom_pc, r_cur_mask}
                                           : {r_fall_pc, r_n_mask};
  assign w_mem_we  = w_push && !w_flush_cur;
  assign w_mem_re  = (r_state == S_POP);

  // Single-port entry array with registered read, no reset on storage
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
    if (w_mem_re) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

endmodule

// File: tb/tb_ipdom_reconv_ctrl.sv
// Bench for ipdom_reconv_ctrl: directed steps followed by random split/join/flush
// traffic, all checked against a per-warp array-based stack model.
module tb_ipdom_reconv_ctrl;

  localparam int NW = 8;
  localparam int NT = 32;
  localparam int PW = 32;
  localparam int SD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic          op_is_join = 1'b0;
  logic [2:0]    op_warp_id = '0;
  logic [NT-1:0] op_cur_mask = '0;
  logic [NT-1:0] op_taken_mask = '0;
  logic [PW-1:0] op_taken_pc = '0;
  logic [PW-1:0] op_fallthru_pc = '0;
  logic [PW-1:0] op_ipdom_pc = '0;
  logic          flush_valid = 1'b0;
  logic [2:0]    flush_warp_id = '0;
  logic          upd_valid;
  logic [2:0]    upd_warp_id;
  logic [PW-1:0] upd_pc;
  logic [NT-1:0] upd_mask;
  logic          upd_err;
  logic [NW-1:0] stack_empty;
  logic [NW-1:0] stack_full;

  ipdom_reconv_ctrl #(
    .NUM_WARPS(NW), .NUM_THREADS(NT), .PC_WIDTH(PW), .STACK_DEPTH(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_is_join(op_is_join),
    .op_warp_id(op_warp_id), .op_cur_mask(op_cur_mask), .op_taken_mask(op_taken_mask),
    .op_taken_pc(op_taken_pc), .op_fallthru_pc(op_fallthru_pc), .op_ipdom_pc(op_ipdom_pc),
    .flush_valid(flush_valid), .flush_warp_id(flush_warp_id),
    .upd_valid(upd_valid), .upd_warp_id(upd_warp_id), .upd_pc(upd_pc),
    .upd_mask(upd_mask), .upd_err(upd_err),
    .stack_empty(stack_empty), .stack_full(stack_full)
  );

  always #5 clk = ~clk;

  // Reference model: each warp is a plain array-backed stack
  typedef struct packed {
    logic [PW-1:0] pc;
    logic [NT-1:0] mask;
  } ent_t;

  ent_t mstk [NW][SD];
  int   msz  [NW];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    logic [NW-1:0] e_empty;
    logic [NW-1:0] e_full;
    for (int i = 0; i < NW; i++) begin
      e_empty[i] = (msz[i] == 0);
      e_full[i]  = (msz[i] > SD - 2);
    end
    check($sformatf("%s/stack_empty", tag), stack_empty, e_empty);
    check($sformatf("%s/stack_full", tag), stack_full, e_full);
  endtask

  // Issue one operation; optionally flush warp fw during post-accept cycle flush_at.
  task automatic run_op(input string tag, input bit is_join, input int w,
                        input logic [NT-1:0] cur, input logic [NT-1:0] taken,
                        input logic [PW-1:0] tpc, input logic [PW-1:0] fpc,
                        input logic [PW-1:0] ipc, input int flush_at, input int fw);
    logic [NT-1:0] t, n;
    logic [PW-1:0] exp_pc;
    logic [NT-1:0] exp_mask;
    bit            exp_err, div, do_flush, abort;
    int            exp_lat, rdy_cyc, waits, n_high, obs_lat;
    logic [PW-1:0] o_pc;
    logic [NT-1:0] o_mask;
    logic          o_err, rdy_after;
    logic [2:0]    o_wid;

    t = taken & cur;
    n = cur & ~t;
    exp_pc = '0; exp_mask = '0; exp_err = 1'b0; div = 1'b0;
    if (is_join) begin
      if (msz[w] == 0) begin
        exp_err = 1'b1; exp_lat = 1;
      end else begin
        exp_lat = 2;
        exp_pc = mstk[w][msz[w]-1].pc;
        exp_mask = mstk[w][msz[w]-1].mask;
      end
    end else if (t == '0) begin
      exp_lat = 1; exp_pc = fpc; exp_mask = cur;
    end else if (n == '0) begin
      exp_lat = 1; exp_pc = tpc; exp_mask = cur;
    end else if (SD - msz[w] < 2) begin
      exp_lat = 1; exp_err = 1'b1;
    end else begin
      exp_lat = 3; div = 1'b1; exp_pc = tpc; exp_mask = t;
    end
    do_flush = (flush_at >= 1) && (flush_at < exp_lat);
    abort    = do_flush && (fw == w);
    rdy_cyc  = abort ? flush_at + 1 : exp_lat + 1;

    waits = 0;
    while (!op_ready && waits < 20) begin
      @(posedge clk); #1; waits++;
    end
    check($sformatf("%s/ready_before", tag), op_ready, 1);

    op_is_join = is_join; op_warp_id = 3'(w); op_cur_mask = cur; op_taken_mask = taken;
    op_taken_pc = tpc; op_fallthru_pc = fpc; op_ipdom_pc = ipc; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;

    n_high = 0; obs_lat = 0; o_pc = '0; o_mask = '0; o_err = 1'b0; o_wid = '0; rdy_after = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (do_flush && c == flush_at) begin
        flush_valid = 1'b1; flush_warp_id = 3'(fw);
      end
      if (c == rdy_cyc) rdy_after = op_ready;
      if (upd_valid === 1'b1) begin
        n_high++;
        if (obs_lat == 0) begin
          obs_lat = c; o_pc = upd_pc; o_mask = upd_mask; o_err = upd_err; o_wid = upd_warp_id;
        end
      end
      @(posedge clk); #1;
      flush_valid = 1'b0;
    end

    if (do_flush) msz[fw] = 0;
    if (!abort) begin
      if (is_join && !exp_err) msz[w]--;
      if (div) begin
        mstk[w][msz[w]] = '{pc: ipc, mask: cur};
        mstk[w][msz[w]+1] = '{pc: fpc, mask: n};
        msz[w] += 2;
      end
    end

    check($sformatf("%s/upd_pulses", tag), n_high, abort ? 0 : 1);
    if (!abort) begin
      check($sformatf("%s/latency", tag), obs_lat, exp_lat);
      check($sformatf("%s/upd_err", tag), o_err, exp_err);
      check($sformatf("%s/upd_warp_id", tag), o_wid, w);
      if (!exp_err) begin
        check($sformatf("%s/upd_pc", tag), o_pc, exp_pc);
        check($sformatf("%s/upd_mask", tag), o_mask, exp_mask);
      end
    end
    check($sformatf("%s/ready_after", tag), rdy_after, 1);
    check_status(tag);
    $display("op %s join=%0d w=%0d lat=%0d err=%0d pc=%h mask=%h abort=%0d", tag, is_join, w,
             obs_lat, o_err, o_pc, o_mask, abort);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s/op_ready", tag), op_ready, 0);
    check($sformatf("%s/upd_valid", tag), upd_valid, 0);
    check($sformatf("%s/upd_err", tag), upd_err, 0);
    check($sformatf("%s/upd_warp_id", tag), upd_warp_id, 0);
    check($sformatf("%s/upd_pc", tag), upd_pc, 0);
    check($sformatf("%s/upd_mask", tag), upd_mask, 0);
    check($sformatf("%s/stack_empty", tag), stack_empty, {NW{1'b1}});
    check($sformatf("%s/stack_full", tag), stack_full, '0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NT-1:0] cur, taken;
    int w, fa, fw, sel;
    bit j;

    for (int i = 0; i < NW; i++) msz[i] = 0;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    #29 rst_n = 1'b1;
    @(posedge clk); #1;
    check("por/ready_after_release", op_ready, 1);

    // Divergent split then two joins on w3
    run_op("div_w3", 0, 3, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h100, 32'h104, 32'h200, 0, 0);
    run_op("join1_w3", 1, 3, '0, '0, '0, '0, '0, 0, 0);
    run_op("join2_w3", 1, 3, '0, '0, '0, '0, '0, 0, 0);

    // Uniform splits
    run_op("uni_nt_w2", 0, 2, 32'h0F0F_0F0F, 32'h0, 32'h300, 32'h304, 32'h400, 0, 0);
    run_op("uni_tk_w2", 0, 2, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h500, 32'h504, 32'h600, 0, 0);
    run_op("uni_eq_w2", 0, 2, 32'h00F0_0001, 32'h00F0_0001, 32'h700, 32'h704, 32'h800, 0, 0);

    // Overflow on w0: four fill it, the fifth errors
    for (int k = 0; k < 5; k++)
      run_op($sformatf("ovf%0d_w0", k), 0, 0, 32'hFFFF_FFFF, 32'h1234_5678,
             32'h1000 + 32'(k * 16), 32'h2000 + 32'(k * 16), 32'h3000 + 32'(k * 16), 0, 0);

    // Underflow on empty w5
    run_op("unf_w5", 1, 5, '0, '0, '0, '0, '0, 0, 0);

    // Flush w3 while its split sits in PUSH_N
    run_op("flush_pushn_w3", 0, 3, 32'hFFFF_FFFF, 32'h00FF_00FF, 32'h900, 32'h904, 32'hA00, 2, 3);
    // Flush w4 while its join sits in POP
    run_op("fill_w4", 0, 4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hB00, 32'hB04, 32'hC00, 0, 0);
    run_op("flush_pop_w4", 1, 4, '0, '0, '0, '0, '0, 1, 4);
    // Flush of w1 during a w3 split does not disturb the split
    run_op("fill_w1", 0, 1, 32'h0000_00FF, 32'h0000_000F, 32'hD00, 32'hD04, 32'hE00, 0, 0);
    run_op("flush_other_w3", 0, 3, 32'hAAAA_5555, 32'hFFFF_0000, 32'hF00, 32'hF04, 32'hF80, 1, 1);

    // Reset in the middle of a divergent split on w6 (DUT in PUSH_R)
    op_is_join = 1'b0; op_warp_id = 3'd6; op_cur_mask = 32'hFFFF_FFFF;
    op_taken_mask = 32'h0000_0F0F; op_taken_pc = 32'h4000; op_fallthru_pc = 32'h4004;
    op_ipdom_pc = 32'h4100; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < NW; i++) msz[i] = 0;
    @(posedge clk); #1;
    run_op("post_rst_join_w6", 1, 6, '0, '0, '0, '0, '0, 0, 0);

    // Randomized traffic with occasional in-flight and idle flushes
    for (int k = 0; k < 250; k++) begin
      w = int'($urandom_range(0, NW - 1));
      j = ($urandom_range(0, 9) < 4);
      sel = int'($urandom_range(0, 15));
      cur = (sel == 0) ? '0 : (sel < 4) ? {NT{1'b1}} : $urandom;
      sel = int'($urandom_range(0, 5));
      taken = (sel == 0) ? '0 : (sel == 1) ? cur : $urandom;
      fa = 0; fw = 0;
      if ($urandom_range(0, 4) == 0) begin
        fa = int'($urandom_range(1, 2));
        fw = int'($urandom_range(0, NW - 1));
      end
      run_op($sformatf("rnd%0d", k), j, w, cur, taken, {$urandom} & 32'hFFFF_FFFC,
             {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC, fa, fw);
      if ($urandom_range(0, 9) == 0) begin
        fw = int'($urandom_range(0, NW - 1));
        flush_valid = 1'b1; flush_warp_id = 3'(fw);
        @(posedge clk); #1;
        flush_valid = 1'b0;
        msz[fw] = 0;
        check_status($sformatf("idle_flush%0d_w%0d", k, fw));
        $display("idle flush w=%0d empty=%b", fw, stack_empty);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
